// File: rtl/aurora_prbs15_checker.sv
// Self-synchronising PRBS15 word checker: seeds from received data, flywheels once locked.
// Optional build macro PRBS_CHK_BITCOUNT_EN makes Err_Cnt count bit errors instead of word errors.
module aurora_prbs15_checker #(
   parameter int WIDTH      = 20,
   parameter int TAP1       = 15,
   parameter int TAP2       = 14,
   parameter int LOCK_CNT   = 8,
   parameter int UNLOCK_ERR = 4,
   parameter int CNT_W      = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] Data_In,
   input  logic             Data_Valid,
   input  logic             Clear_Cnt,
   output logic             Locked,
   output logic             Error,
   output logic [CNT_W-1:0] Err_Cnt,
   output logic [CNT_W-1:0] Word_Cnt
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_ERR + 1);
   localparam int PW = $clog2(WIDTH + 1);
   localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] expected, r, exp_word, mism;
   logic [MW-1:0]    match_cnt;
   logic [BW-1:0]    bad_cnt;
   logic             seeded, match_ok, bad, lock_now, unlock_now;
   logic [PW-1:0]    err_inc;
   logic [SW-1:0]    err_sum;
   logic [CNT_W-1:0] err_next;

   function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] y;
      for (int i = 0; i < WIDTH; i++) y[i] = x[WIDTH-1-i];
      return y;
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] s;
      s = x;
      for (int k = 0; k < WIDTH; k++) s = {s[WIDTH-2:0], s[TAP1-1] ^ s[TAP2-1]};
      return s;
   endfunction

   function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] x);
      logic [PW-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) n = n + PW'(x[i]);
      return n;
   endfunction

   always_comb begin
      r          = reverse(Data_In);
      exp_word   = reverse(expected);
      mism       = Data_In ^ exp_word;
      bad        = (mism != '0);
      // An all-zero word is the LFSR lock-up state, so it never counts towards lock.
      match_ok   = seeded && !bad && (Data_In != '0);
      lock_now   = Data_Valid && (state == SEARCH) && match_ok &&
                   (match_cnt == MW'(LOCK_CNT - 1));
      unlock_now = Data_Valid && (state == LOCKED) && bad &&
                   (bad_cnt == BW'(UNLOCK_ERR - 1));
`ifdef PRBS_CHK_BITCOUNT_EN
      err_inc    = popcount(mism);
`else
      err_inc    = PW'(1);
`endif
      err_sum    = {{(SW-CNT_W){1'b0}}, Err_Cnt} + SW'(err_inc);
      err_next   = (err_sum > CNT_MAX) ? '1 : err_sum[CNT_W-1:0];
   end

   // NOTE: every variable in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         SEARCH:  if (lock_now)   next_state = LOCKED;
         LOCKED:  if (unlock_now) next_state = SEARCH;
         default: next_state = SEARCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= SEARCH;
      else      state <= next_state;
   end

   assign Locked = (state == LOCKED);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         expected  <= '0;
         seeded    <= 1'b0;
         match_cnt <= '0;
         bad_cnt   <= '0;
         Error     <= 1'b0;
         Err_Cnt   <= '0;
         Word_Cnt  <= '0;
      end else begin
         Error <= 1'b0;
         if (Data_Valid) begin
            if (state == SEARCH) begin
               expected  <= advance(r);
               seeded    <= 1'b1;
               bad_cnt   <= '0;
               match_cnt <= (match_ok && !lock_now) ? match_cnt + MW'(1) : '0;
            end else begin
               // Flywheel: prediction never comes from the data, so bit errors do not propagate.
               expected <= advance(expected);
               if (bad) begin
                  Error <= 1'b1;
                  if (unlock_now) begin
                     bad_cnt   <= '0;
                     match_cnt <= '0;
                     seeded    <= 1'b0;
                  end else begin
                     bad_cnt <= bad_cnt + BW'(1);
                  end
               end else begin
                  bad_cnt <= '0;
               end
            end
         end
         if (Clear_Cnt) begin
            Err_Cnt  <= '0;
            Word_Cnt <= '0;
         end else if (Data_Valid && (state == LOCKED)) begin
            if (Word_Cnt != '1) Word_Cnt <= Word_Cnt + CNT_W'(1);
            if (bad)            Err_Cnt  <= err_next;
         end
      end
   end

endmodule

// File: tb/tb_aurora_prbs15_checker.sv
// Table-driven bench for aurora_prbs15_checker: vectors are applied word by word and their
// hand-derived expected outputs are queued and compared one cycle later.
module tb_aurora_prbs15_checker;

   localparam int W  = 20;
   localparam int CW = 4;
`ifdef PRBS_CHK_BITCOUNT_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif
   localparam int E3 = BC ? 3 : 1;

   logic          clk;
   logic          rst;
   logic [W-1:0]  data_in;
   logic          data_valid;
   logic          clear_cnt;
   logic          locked;
   logic          error;
   logic [CW-1:0] err_cnt;
   logic [CW-1:0] word_cnt;

   aurora_prbs15_checker #(
      .WIDTH(W), .TAP1(15), .TAP2(14), .LOCK_CNT(8), .UNLOCK_ERR(4), .CNT_W(CW)
   ) dut (
      .Clk(clk), .Rst(rst), .Data_In(data_in), .Data_Valid(data_valid),
      .Clear_Cnt(clear_cnt), .Locked(locked), .Error(error),
      .Err_Cnt(err_cnt), .Word_Cnt(word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         valid;
      bit         zero;
      logic [W-1:0] flip;
      bit         clear;
      bit         e_locked;
      bit         e_error;
      int         e_err;
      int         e_wc;
   } vec_t;

   typedef struct {
      int idx;
      bit l;
      bit e;
      int err;
      int wc;
   } exp_t;

   vec_t         vecs[$];
   exp_t         sb[$];
   int           split_idx;
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] gen;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic void add(input bit v, input bit z, input logic [W-1:0] f, input bit c,
                               input bit l, input bit e, input int err, input int wc);
      vec_t t;
      t.valid = v; t.zero = z; t.flip = f; t.clear = c;
      t.e_locked = l; t.e_error = e; t.e_err = err; t.e_wc = wc;
      vecs.push_back(t);
   endfunction

   function automatic void clean(input bit l, input int err, input int wc);
      add(1'b1, 1'b0, '0, 1'b0, l, 1'b0, err, wc);
   endfunction

   function automatic logic [W-1:0] rev(input logic [W-1:0] x);
      logic [W-1:0] y;
      for (int i = 0; i < W; i++) y[i] = x[W-1-i];
      return y;
   endfunction

   // Reference PRBS15 word generator stepped serially, W steps per word.
   task automatic gen_step();
      for (int s = 0; s < W; s++) gen = {gen[W-2:0], gen[14] ^ gen[13]};
   endtask

   task automatic drain();
      exp_t x;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         check($sformatf("v%0d locked", x.idx), int'(locked), int'(x.l));
         check($sformatf("v%0d error", x.idx), int'(error), int'(x.e));
         check($sformatf("v%0d err_cnt", x.idx), int'(err_cnt), x.err);
         check($sformatf("v%0d word_cnt", x.idx), int'(word_cnt), x.wc);
      end
   endtask

   task automatic drive(input int i);
      exp_t x;
      data_valid = vecs[i].valid;
      clear_cnt  = vecs[i].clear;
      data_in    = vecs[i].zero ? '0 : (rev(gen) ^ vecs[i].flip);
      if (vecs[i].valid && !vecs[i].zero) gen_step();
      x.idx = i; x.l = vecs[i].e_locked; x.e = vecs[i].e_error;
      x.err = vecs[i].e_err; x.wc = vecs[i].e_wc;
      sb.push_back(x);
   endtask

   task automatic idle();
      data_valid = 1'b0;
      clear_cnt  = 1'b0;
      data_in    = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " locked"}, int'(locked), 0);
      check({tag, " error"}, int'(error), 0);
      check({tag, " err_cnt"}, int'(err_cnt), 0);
      check({tag, " word_cnt"}, int'(word_cnt), 0);
   endtask

   task automatic build_table();
      // Segment 0: lock from all-ones seed, single/multi-bit errors, unlock/relock, clear.
      for (int k = 1; k <= 9; k++) clean(k == 9, 0, 0);
      for (int k = 1; k <= 3; k++) clean(1'b1, 0, k);
      add(1'b1, 1'b0, W'(1) << 3, 1'b0, 1'b1, 1'b1, 1, 4);
      clean(1'b1, 1, 5);
      add(1'b1, 1'b0, W'('h15), 1'b0, 1'b1, 1'b1, 1 + E3, 6);
      clean(1'b1, 1 + E3, 7);
      for (int k = 1; k <= 4; k++) add(1'b1, 1'b0, W'(1), 1'b0, k < 4, 1'b1, 1 + E3 + k, 7 + k);
      for (int k = 1; k <= 9; k++) clean(k == 9, 5 + E3, 11);
      clean(1'b1, 5 + E3, 12);
      add(1'b1, 1'b0, W'(1) << 5, 1'b1, 1'b1, 1'b1, 0, 0);
      clean(1'b1, 0, 1);
      split_idx = vecs.size();
      // Segment 1 (after async reset): all-zero words, gapped valid, saturation.
      for (int k = 0; k < 50; k++) add(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int k = 1; k <= 9; k++) begin
         clean(k == 9, 0, 0);
         add(1'b0, 1'b0, W'('h3c3), 1'b0, k == 9, 1'b0, 0, 0);
      end
      clean(1'b1, 0, 1);
      clean(1'b1, 0, 2);
      for (int j = 1; j <= 3; j++) begin
         add(1'b1, 1'b0, W'('h7f), 1'b0, 1'b1, 1'b1, BC ? ((7 * j > 15) ? 15 : 7 * j) : j, 2 * j + 1);
         clean(1'b1, BC ? ((7 * j > 15) ? 15 : 7 * j) : j, 2 * j + 2);
      end
      for (int k = 1; k <= 10; k++) clean(1'b1, BC ? 15 : 3, (8 + k > 15) ? 15 : 8 + k);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      gen = '1;
      build_table();
      #2 rst = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drain();
         if (i == split_idx) begin
            idle();
            #1 rst = 1'b0;
            #1 check_reset_outputs("async reset");
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
         end
         drive(i);
      end
      @(negedge clk);
      drain();
      idle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
